spi_register_queue: RTL and testbench
=====================================

Name: spi_register_queue

Overview:
- Sits directly downstream of the SPI slave.
- Converts its level-style register-write output (enable held high from command completion until the next command starts or NSS rises) into single-shot writes.
- Decodes each register number into target class plus address, buffers writes in a small FIFO, and drains them to the synth parameter bus through a valid/ready handshake.
- Gives the voice/operator pipeline freedom to stall parameter updates without losing SPI commands.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- COUNT_WIDTH, 8, width of the saturating drop/invalid counters.

Ports:
- i_Clock  input  1  system clock
- i_Reset  input  1  synchronous, active-high reset
- i_RegisterWriteEnable  input  1  level from SPI slave; high while a completed command is held
- i_RegisterWriteNumber  input  16  register number from SPI slave
- i_RegisterWriteValue  input  16  register value from SPI slave
- o_ParamWriteValid  output  1  head entry present on parameter bus
- i_ParamWriteReady  input  1  consumer accepts head this cycle
- o_ParamWriteTarget  output  2  target class (GLOBAL=0, OPERATOR=1, ENVELOPE=2, VOICE=3)
- o_ParamWriteAddress  output  12  register number bits [11:0]
- o_ParamWriteData  output  16  register value
- o_QueueFull  output  1  FIFO holds DEPTH entries
- o_DropCount  output  COUNT_WIDTH  valid writes lost to overflow, saturating
- o_InvalidCount  output  COUNT_WIDTH  writes with illegal class, saturating

Behaviour:
- Clock and reset: one clock, i_Clock. i_Reset is synchronous and active-high.
- Reset state (next edge with i_Reset high):
  - FIFO emptied; o_ParamWriteValid=0, o_QueueFull=0.
  - Both counters 0; enable-history register 0.
  - Target/address/data outputs 0.
- Reset mid-drain: the head entry is discarded even if valid was high; no handshake completes that cycle.
- Edge detect:
  - r_EnableLast registers i_RegisterWriteEnable every cycle.
  - Push request = enable && !r_EnableLast.
  - A level held for many cycles yields exactly one request.
  - Enable high on the first cycle after reset counts as a request.
- Decode, at push time:
  - class = number[15:12].
  - Values 0–3 map to the 2-bit target; address = number[11:0].
  - Class 4–15 is invalid: the write is not pushed and o_InvalidCount increments (saturating at all-ones). The drop counter is not affected.
- FIFO:
  - Stores {target, address, data}, 30 bits per entry.
  - Read and write pointers are log2(DEPTH) bits and wrap naturally; an occupancy count of log2(DEPTH)+1 bits gives full/empty.
  - Pop occurs when o_ParamWriteValid && i_ParamWriteReady.
  - Push when not full: accepted.
  - Push when full with a simultaneous pop: accepted; occupancy unchanged.
  - Push when full without a pop: the entry is dropped, the FIFO is unchanged, and o_DropCount increments (saturating).
  - Push and pop on an empty FIFO: impossible, since valid=0 when empty.
- Outputs:
  - o_ParamWriteValid = (count != 0).
  - Target, address and data come combinationally from the head entry.
  - Outputs stay stable while valid && !ready.
  - When the FIFO is empty, outputs show the stale head slot; the consumer must ignore them.
- Latency: a rising enable sampled at clock edge N is written at edge N; o_ParamWriteValid is high after edge N (cycle N+1) if the FIFO was empty. One cycle from edge to bus.
- Throughput: one pop per cycle. SPI SCK is at least 8x slower than i_Clock, so with ready held high the FIFO never fills.
- o_QueueFull = (count == DEPTH).

Decomposition:
- Package octane_regmap_pkg holds:
  - the param-target enum (2 bits) and register-number field positions (class [15:12], address [11:0]);
  - the constant NUM_VALID_CLASSES=4;
  - the parameter-write struct {target, address, data}.
  - The SPI slave and downstream parameter RAMs share this package.
- One sub-module: sync_fifo.
  - Parameters: WIDTH, DEPTH. Ports: push, pop, wdata, rdata, full, empty, count.
  - Single clock, synchronous reset.
  - Push-when-full-with-pop handled inside.
- The top level holds the edge detect, decode and counters.

Test Plan:
- Reset, then enable held high for 40 cycles with number=0x1023, value=0xBEEF, ready=1 → exactly one handshake: target=1, address=0x023, data=0xBEEF, valid high on the cycle after the edge; counters 0.
- Number=0x7001 pulsed → no valid; o_InvalidCount=1; o_DropCount=0.
- Ready=0, six distinct valid writes (numbers 0x0000–0x0005) → o_QueueFull after the 4th; o_DropCount=2. Then ready=1 → four pops in order with addresses 0x000–0x003, one per cycle.
- FIFO full, ready=1 and a push edge on the same cycle → push accepted, count stays 4, o_DropCount unchanged, the new entry emerges last.
- 300 invalid writes → o_InvalidCount saturates at 255 and does not wrap.
- Three entries queued with valid high and ready=0, then i_Reset pulsed for 1 cycle → valid=0 the next cycle, counters 0; the next write emerges alone with no stale entries.

Source files
------------

// File: rtl/octane_regmap_pkg.sv
// Register map shared by the SPI slave, the register write queue and the parameter RAMs.
// Register number layout: class in [15:12], address in [11:0].
package octane_regmap_pkg;

    typedef enum logic [1:0] {
        TARGET_GLOBAL   = 2'd0,
        TARGET_OPERATOR = 2'd1,
        TARGET_ENVELOPE = 2'd2,
        TARGET_VOICE    = 2'd3
    } param_target_e;

    localparam int CLASS_MSB = 15;
    localparam int CLASS_LSB = 12;
    localparam int ADDR_MSB  = 11;
    localparam int ADDR_LSB  = 0;

    localparam int NUM_VALID_CLASSES = 4;

    typedef struct packed {
        param_target_e target;
        logic [11:0]   address;
        logic [15:0]   data;
    } param_write_t;

endpackage

// File: rtl/spi_register_queue_sync_fifo.sv
// Single-clock FIFO with synchronous reset. A push while full is still accepted
// when a pop happens on the same cycle, because the popped slot frees up at that edge.
module sync_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 4
) (
    input  logic                     i_Clock,
    input  logic                     i_Reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             pop_ok;
    logic             push_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Slots are cleared on reset so the stale head reads as zero afterwards.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/spi_register_queue.sv
// Turns the SPI slave's held write-enable level into single-shot register writes,
// decodes them into target/address and queues them for the parameter bus.
module spi_register_queue
    import octane_regmap_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_RegisterWriteEnable,
    input  logic [15:0]            i_RegisterWriteNumber,
    input  logic [15:0]            i_RegisterWriteValue,
    output logic                   o_ParamWriteValid,
    input  logic                   i_ParamWriteReady,
    output logic [1:0]             o_ParamWriteTarget,
    output logic [11:0]            o_ParamWriteAddress,
    output logic [15:0]            o_ParamWriteData,
    output logic                   o_QueueFull,
    output logic [COUNT_WIDTH-1:0] o_DropCount,
    output logic [COUNT_WIDTH-1:0] o_InvalidCount
);

    localparam int AW = $clog2(DEPTH);

    logic                   enable_last_q;
    logic [COUNT_WIDTH-1:0] drop_count_q;
    logic [COUNT_WIDTH-1:0] invalid_count_q;

    logic                   push_req;
    logic [3:0]             reg_class;
    logic                   class_valid;
    logic                   push;
    logic                   pop;
    logic                   drop_inc;
    logic                   invalid_inc;
    param_write_t           wr_entry;
    param_write_t           head;
    logic [$bits(param_write_t)-1:0] fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [AW:0]            fifo_count;

    assign push_req    = i_RegisterWriteEnable && !enable_last_q;
    assign reg_class   = i_RegisterWriteNumber[CLASS_MSB:CLASS_LSB];
    assign class_valid = (reg_class < 4'(NUM_VALID_CLASSES));

    assign push        = push_req && class_valid;
    assign invalid_inc = push_req && !class_valid;
    assign pop         = o_ParamWriteValid && i_ParamWriteReady;
    assign drop_inc    = push && fifo_full && !pop;

    always_comb begin
        wr_entry         = '0;
        wr_entry.target  = param_target_e'(reg_class[1:0]);
        wr_entry.address = i_RegisterWriteNumber[ADDR_MSB:ADDR_LSB];
        wr_entry.data    = i_RegisterWriteValue;
    end

    sync_fifo #(
        .WIDTH ($bits(param_write_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head                = fifo_rdata;
    assign o_ParamWriteValid   = !fifo_empty;
    assign o_QueueFull         = (fifo_count == (AW+1)'(DEPTH));
    assign o_ParamWriteTarget  = head.target;
    assign o_ParamWriteAddress = head.address;
    assign o_ParamWriteData    = head.data;
    assign o_DropCount         = drop_count_q;
    assign o_InvalidCount      = invalid_count_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            enable_last_q   <= 1'b0;
            drop_count_q    <= '0;
            invalid_count_q <= '0;
        end else begin
            enable_last_q <= i_RegisterWriteEnable;
            if (drop_inc && (drop_count_q != '1)) begin
                drop_count_q <= drop_count_q + 1'b1;
            end
            if (invalid_inc && (invalid_count_q != '1)) begin
                invalid_count_q <= invalid_count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_register_queue.sv
// Directed bench for spi_register_queue: edge detect, decode, FIFO overflow,
// full-with-pop, counter saturation and reset mid-drain.
module tb_spi_register_queue;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_num;
    logic [15:0] wr_val;
    logic        valid;
    logic        ready;
    logic [1:0]  target;
    logic [11:0] address;
    logic [15:0] data;
    logic        full;
    logic [7:0]  drop_cnt;
    logic [7:0]  inv_cnt;

    int n_checks;
    int n_fail;
    int n_pops;
    logic [29:0] exp_q[$];

    spi_register_queue #(.DEPTH(4), .COUNT_WIDTH(8)) dut (
        .i_Clock               (clk),
        .i_Reset               (rst),
        .i_RegisterWriteEnable (wr_en),
        .i_RegisterWriteNumber (wr_num),
        .i_RegisterWriteValue  (wr_val),
        .o_ParamWriteValid     (valid),
        .i_ParamWriteReady     (ready),
        .o_ParamWriteTarget    (target),
        .o_ParamWriteAddress   (address),
        .o_ParamWriteData      (data),
        .o_QueueFull           (full),
        .o_DropCount           (drop_cnt),
        .o_InvalidCount        (inv_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: a handshake about to happen on the next edge must match the queue head
    task automatic check_bus();
        logic [29:0] e;
        if (valid && ready) begin
            n_pops++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pop", {2'b0, target, address, data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("pop_entry", {2'b0, target, address, data}, {2'b0, e});
            end
        end
    endtask

    task automatic step();
        check_bus();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // one enable pulse: high for one cycle, low for one cycle
    task automatic write_reg(input logic [15:0] num, input logic [15:0] val);
        wr_num = num;
        wr_val = val;
        wr_en  = 1'b1;
        step();
        wr_en  = 1'b0;
        step();
    endtask

    function automatic logic [29:0] entry(input logic [15:0] num, input logic [15:0] val);
        return {num[13:12], num[11:0], val};
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_pops   = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_num   = 16'h0;
        wr_val   = 16'h0;
        ready    = 1'b0;
        @(negedge clk);
        steps(2);
        rst = 1'b0;

        // reset state
        check_eq("rst_valid", valid, 0);
        check_eq("rst_full", full, 0);
        check_eq("rst_drop", drop_cnt, 0);
        check_eq("rst_inv", inv_cnt, 0);
        check_eq("rst_bus", {target, address, data}, 0);

        // held level gives exactly one write
        wr_num = 16'h1023;
        wr_val = 16'hBEEF;
        wr_en  = 1'b1;
        ready  = 1'b1;
        exp_q.push_back(entry(16'h1023, 16'hBEEF));
        step();
        check_eq("t1_valid_next", valid, 1);
        check_eq("t1_target", target, 1);
        check_eq("t1_addr", address, 12'h023);
        check_eq("t1_data", data, 16'hBEEF);
        steps(39);
        wr_en = 1'b0;
        step();
        check_eq("t1_pops", n_pops, 1);
        check_eq("t1_valid_after", valid, 0);
        check_eq("t1_drop", drop_cnt, 0);
        check_eq("t1_inv", inv_cnt, 0);

        // invalid class
        wr_num = 16'h7001;
        wr_val = 16'h1111;
        wr_en  = 1'b1;
        step();
        check_eq("t2_valid", valid, 0);
        check_eq("t2_inv", inv_cnt, 1);
        check_eq("t2_drop", drop_cnt, 0);
        wr_en = 1'b0;
        step();

        // overflow with ready low
        ready  = 1'b0;
        n_pops = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back(entry(16'(i), 16'hA000 + 16'(i)));
            write_reg(16'(i), 16'hA000 + 16'(i));
            if (i == 2) check_eq("t3_not_full_3", full, 0);
            if (i == 3) check_eq("t3_full_4", full, 1);
        end
        check_eq("t3_drop", drop_cnt, 2);
        check_eq("t3_inv", inv_cnt, 1);
        check_eq("t3_valid", valid, 1);
        ready = 1'b1;
        steps(4);
        check_eq("t3_pops", n_pops, 4);
        check_eq("t3_empty", valid, 0);
        check_eq("t3_q_left", exp_q.size(), 0);

        // full FIFO, pop and push on the same edge
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(entry(16'h2010 + 16'(i), 16'hC000 + 16'(i)));
            write_reg(16'h2010 + 16'(i), 16'hC000 + 16'(i));
        end
        check_eq("t4_full_before", full, 1);
        n_pops = 0;
        ready  = 1'b1;
        wr_num = 16'h3ABC;
        wr_val = 16'h1234;
        wr_en  = 1'b1;
        exp_q.push_back(entry(16'h3ABC, 16'h1234));
        step();
        wr_en = 1'b0;
        check_eq("t4_full_after", full, 1);
        check_eq("t4_drop", drop_cnt, 2);
        steps(4);
        check_eq("t4_pops", n_pops, 5);
        check_eq("t4_empty", valid, 0);
        check_eq("t4_q_left", exp_q.size(), 0);

        // invalid counter saturation
        for (int i = 0; i < 300; i++) begin
            write_reg(16'hF000 + 16'(i), 16'h0);
            if (i == 199) check_eq("t5_inv_201", inv_cnt, 201);
            if (i == 253) check_eq("t5_inv_255", inv_cnt, 255);
        end
        check_eq("t5_inv_sat", inv_cnt, 255);
        check_eq("t5_drop", drop_cnt, 2);
        check_eq("t5_valid", valid, 0);

        // reset mid-drain
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            write_reg(16'h0100 + 16'(i), 16'h7700 + 16'(i));
        end
        check_eq("t6_valid_pre", valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check_eq("t6_valid_rst", valid, 0);
        check_eq("t6_full_rst", full, 0);
        check_eq("t6_drop_rst", drop_cnt, 0);
        check_eq("t6_inv_rst", inv_cnt, 0);
        check_eq("t6_bus_rst", {target, address, data}, 0);
        n_pops = 0;
        ready  = 1'b1;
        wr_num = 16'h3FFF;
        wr_val = 16'h5555;
        wr_en  = 1'b1;
        exp_q.push_back(entry(16'h3FFF, 16'h5555));
        step();
        wr_en = 1'b0;
        check_eq("t6_valid_new", valid, 1);
        check_eq("t6_target_new", target, 3);
        steps(3);
        check_eq("t6_pops", n_pops, 1);
        check_eq("t6_empty", valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
